// File: rtl/fe_pkg.sv
// ============================================================================
// Module  : fe_pkg
// Purpose : Shared front-end types and decode-queue sizing constants.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fe_pkg;

  typedef enum logic [1:0] {
    DQ_RUN    = 2'd0,
    DQ_FLUSH  = 2'd1,
    DQ_REFILL = 2'd2
  } dq_state_t;

  localparam int DQ_DEPTH        = 8;
  localparam int DQ_HIGH_WATER   = 6;
  localparam int DQ_FLUSH_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/dq_occupancy_counter.sv
// ============================================================================
// Module  : dq_occupancy_counter
// Purpose : Saturating up/down count of decode-queue entries with sync clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dq_occupancy_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (push_i && !pop_i && (count_q != C_MAX)) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/decode_queue_ctrl.sv
// ============================================================================
// Module  : decode_queue_ctrl
// Purpose : Decode-queue stall merge, flush/redirect sequencer, fetch throttle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_queue_ctrl
  import fe_pkg::*;
#(
  parameter int DEPTH        = DQ_DEPTH,
  parameter int HIGH_WATER   = DQ_HIGH_WATER,
  parameter int FLUSH_CYCLES = DQ_FLUSH_CYCLES
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     if_valid,
  input  logic                     rob_full,
  input  logic                     iq_full,
  input  logic                     lsq_full,
  input  logic                     ext_stall,
  input  logic                     redirect_req,
  input  logic [31:0]              redirect_pc,
  output logic                     flush,
  output logic                     STALL,
  output logic                     ID_stall,
  output logic                     fetch_enable,
  output logic                     pc_redirect_valid,
  output logic [31:0]              pc_redirect,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               state
);

  localparam int              OW      = $clog2(DEPTH) + 1;
  localparam int              FCW     = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FCW-1:0]  C_FLAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [OW-1:0]   C_HW    = OW'(HIGH_WATER);

  dq_state_t      state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           flush_q;
  logic           pcv_q;
  logic [31:0]    pc_q;

  logic w_push;
  logic w_pop;
  logic w_clr;

  assign STALL    = ext_stall;
  assign ID_stall = rob_full | iq_full | lsq_full | (state_q != DQ_RUN);

  // A new redirect always wins, restarting the flush from any state.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (redirect_req) begin
      state_d = DQ_FLUSH;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        DQ_FLUSH: begin
          if (!ext_stall) begin
            if (fcnt_q == C_FLAST) begin
              state_d = DQ_REFILL;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_q + FCW'(1);
            end
          end
        end
        DQ_REFILL: begin
          if (if_valid && !ext_stall) begin
            state_d = DQ_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= DQ_RUN;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
      pcv_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= (state_d == DQ_FLUSH);
      pcv_q   <= redirect_req;
      if (redirect_req) begin
        pc_q <= redirect_pc;
      end
    end
  end

  assign w_push = if_valid & ~STALL & (state_q != DQ_FLUSH);
  assign w_pop  = ~ID_stall & ~STALL & (occupancy != '0);
  // The queue ignores flush while frozen, so the shadow count must too.
  assign w_clr  = (state_q == DQ_FLUSH) & ~STALL;

  dq_occupancy_counter #(
    .DEPTH (DEPTH),
    .CW    (OW)
  ) u_occ (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .clr_i   (w_clr),
    .count_o (occupancy)
  );

  assign fetch_enable      = ((state_q == DQ_RUN) || (state_q == DQ_REFILL)) &
                             ~ext_stall & (occupancy < C_HW);
  assign flush             = flush_q;
  assign pc_redirect_valid = pcv_q;
  assign pc_redirect       = pc_q;
  assign state             = state_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue_ctrl.sv
// ============================================================================
// Module  : tb_decode_queue_ctrl
// Purpose : Directed vector table plus reset/saturation sequences.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_queue_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        if_valid, rob_full, iq_full, lsq_full, ext_stall, redirect_req;
  logic [31:0] redirect_pc;
  logic        flush, STALL, ID_stall, fetch_enable, pc_redirect_valid;
  logic [31:0] pc_redirect;
  logic [3:0]  occupancy;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  decode_queue_ctrl dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .if_valid          (if_valid),
    .rob_full          (rob_full),
    .iq_full           (iq_full),
    .lsq_full          (lsq_full),
    .ext_stall         (ext_stall),
    .redirect_req      (redirect_req),
    .redirect_pc       (redirect_pc),
    .flush             (flush),
    .STALL             (STALL),
    .ID_stall          (ID_stall),
    .fetch_enable      (fetch_enable),
    .pc_redirect_valid (pc_redirect_valid),
    .pc_redirect       (pc_redirect),
    .occupancy         (occupancy),
    .state             (state)
  );

  // Expected values are those visible within the cycle the inputs are held.
  typedef struct {
    logic        iv, rob, iq, lsq, ext, rr;
    logic [31:0] rpc;
    logic        fl, st, ids, fe, pcv;
    logic [31:0] pc;
    logic [3:0]  occ;
    logic [1:0]  fsm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, rob, iq, lsq, ext, rr, input logic [31:0] rpc,
                     input logic fl, st, ids, fe, pcv, input logic [31:0] pc,
                     input logic [3:0] occ, input logic [1:0] fsm);
    vec_t v;
    v.iv = iv; v.rob = rob; v.iq = iq; v.lsq = lsq; v.ext = ext; v.rr = rr; v.rpc = rpc;
    v.fl = fl; v.st = st; v.ids = ids; v.fe = fe; v.pcv = pcv; v.pc = pc;
    v.occ = occ; v.fsm = fsm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, rob, iq, lsq, ext, rr, input logic [31:0] rpc);
    if_valid = iv; rob_full = rob; iq_full = iq; lsq_full = lsq;
    ext_stall = ext; redirect_req = rr; redirect_pc = rpc;
  endtask

  initial begin
    //  iv rob iq lsq ext rr rpc            fl st ids fe pcv pc           occ fsm
    for (int k = 0; k < 6; k++)
      add(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 1, 1, 0, 32'h0,        4'(k), 0);
    add(0, 1, 0, 0, 0, 0, 32'h0,            0, 0, 1, 0, 0, 32'h0,        6, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, 32'h0,        6, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 0, 32'h0,        5, 0);
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 32'h0,        4, 0);
    add(1, 1, 0, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h0,        4, 0);
    add(0, 1, 0, 0, 0, 1, 32'h1040,         0, 0, 1, 1, 0, 32'h0,        5, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 1, 32'h1040,     5, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 0, 32'h1040,     0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h1040,     0, 2);
    add(1, 0, 0, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h1040,     0, 2);
    add(0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 0, 32'h1040,     1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 0, 32'h1040,     0, 0);
    add(0, 0, 1, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h1040,     0, 0);
    add(0, 0, 0, 1, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h1040,     0, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,            0, 1, 0, 0, 0, 32'h1040,     0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h3000,         0, 0, 0, 1, 0, 32'h1040,     0, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,            1, 1, 1, 0, 1, 32'h3000,     0, 1);
    add(1, 0, 0, 0, 1, 0, 32'h0,            1, 1, 1, 0, 0, 32'h3000,     0, 1);
    add(1, 0, 0, 0, 1, 0, 32'h0,            1, 1, 1, 0, 0, 32'h3000,     0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 0, 32'h3000,     0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 0, 32'h3000,     0, 1);
    add(1, 0, 0, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h3000,     0, 2);
    add(0, 1, 0, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h3000,     1, 0);
    add(0, 1, 0, 0, 0, 1, 32'h1000,         0, 0, 1, 1, 0, 32'h3000,     1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h2000,         1, 0, 1, 0, 1, 32'h1000,     1, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 1, 32'h2000,     0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 0, 32'h2000,     0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 1, 1, 0, 32'h2000,     0, 2);
    add(0, 0, 0, 0, 0, 1, 32'h44,           0, 0, 1, 1, 0, 32'h2000,     0, 2);
    add(0, 0, 0, 0, 0, 0, 32'h0,            1, 0, 1, 0, 1, 32'h44,       0, 1);

    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #2;
    check("rst.flush", flush, 0);
    check("rst.pcv", pc_redirect_valid, 0);
    check("rst.pc", pc_redirect, 0);
    check("rst.occ", occupancy, 0);
    check("rst.state", state, 0);
    check("rst.fe", fetch_enable, 1);
    ext_stall = 1'b1;
    #1;
    check("rst.fe_ext", fetch_enable, 0);
    ext_stall = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].iv, vecs[i].rob, vecs[i].iq, vecs[i].lsq, vecs[i].ext,
            vecs[i].rr, vecs[i].rpc);
      #1;
      check($sformatf("v%0d.flush", i), flush, vecs[i].fl);
      check($sformatf("v%0d.STALL", i), STALL, vecs[i].st);
      check($sformatf("v%0d.ID_stall", i), ID_stall, vecs[i].ids);
      check($sformatf("v%0d.fetch_enable", i), fetch_enable, vecs[i].fe);
      check($sformatf("v%0d.pcv", i), pc_redirect_valid, vecs[i].pcv);
      check($sformatf("v%0d.pc", i), pc_redirect, vecs[i].pc);
      check($sformatf("v%0d.occ", i), occupancy, vecs[i].occ);
      check($sformatf("v%0d.state", i), state, vecs[i].fsm);
    end

    // Asynchronous reset in the middle of a flush.
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("midrst.pre_flush", flush, 1);
    check("midrst.pre_state", state, 1);
    RESET = 1'b0;
    #1;
    check("midrst.flush", flush, 0);
    check("midrst.state", state, 0);
    check("midrst.pcv", pc_redirect_valid, 0);
    check("midrst.pc", pc_redirect, 0);
    check("midrst.occ", occupancy, 0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      check($sformatf("post%0d.pcv", k), pc_redirect_valid, 0);
      check($sformatf("post%0d.flush", k), flush, 0);
      check($sformatf("post%0d.state", k), state, 0);
    end

    // Pushes past DEPTH saturate at 8.
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      #1;
      check($sformatf("sat%0d.occ", k), occupancy, (k < 8) ? k + 1 : 8);
    end
    check("sat.fe", fetch_enable, 0);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge CLK);
    #1;
    check("sat.pop", occupancy, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
